// File: rtl/ccg_sweep_pkg.sv
// ccg_sweep_pkg: shared state type, default MISR constants and popcount helper
package ccg_sweep_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    function automatic logic [5:0] popcount(input logic [31:0] x);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(x[i]);
        return c;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// ccg_misr: multiple-input signature register folding one response word per enable
module ccg_misr #(
    parameter int             SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] q
);

    // Shift with polynomial feedback, then xor in the new response; load restarts from SEED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else if (load) q <= SEED;
        else if (en) q <= {q[SIG_W-2:0], 1'b0} ^ (q[SIG_W-1] ? POLY : '0) ^ din;
    end

endmodule

// File: rtl/ccg_sig_sweeper.sv
// ccg_sig_sweeper: exhaustive input sweep of a combinational netlist with MISR and ones-count capture
module ccg_sig_sweeper
    import ccg_sweep_pkg::*;
#(
    parameter int          IN_W   = 5,
    parameter int          OUT_W  = 11,
    parameter int          SIG_W  = 16,
    parameter logic [15:0] POLY   = DEF_POLY,
    parameter logic [15:0] SEED   = DEF_SEED,
    parameter int          SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IN_W-1:0]   vec_o,
    input  logic [OUT_W-1:0]  resp_i,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [IN_W+3:0]   ones_total
);

    sweep_state_t    r_state;
    logic [IN_W-1:0] r_vec;
    logic [3:0]      r_hold;
    logic [IN_W+3:0] r_ones;
    logic            r_busy;
    logic            r_done;
    logic            w_load;
    logic            w_sample;

    assign w_load     = (r_state == IDLE) && start;
    assign w_sample   = (r_state == SWEEP) && (r_hold == 4'(SETTLE));
    assign vec_o      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ones_total = r_ones;

    ccg_misr #(
        .SIG_W(SIG_W),
        .POLY (SIG_W'(POLY)),
        .SEED (SIG_W'(SEED))
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .load(w_load),
        .en  (w_sample),
        .din (SIG_W'(resp_i)),
        .q   (signature)
    );

    // Sweep controller: hold each vector SETTLE+1 cycles, sample on the last, stop after the top vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_hold  <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SWEEP;
                    r_vec   <= '0;
                    r_hold  <= '0;
                    r_ones  <= '0;
                    r_busy  <= 1'b1;
                end
                SWEEP: if (w_sample) begin
                    r_hold <= '0;
                    r_vec  <= r_vec + 1'b1;
                    r_ones <= r_ones + (IN_W+4)'(popcount(32'(resp_i)));
                    if (&r_vec) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccg_sig_sweeper.sv
// tb_ccg_sig_sweeper: randomized sweeps of three configurations against an exhaustive reference model
module tb_ccg_sig_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    int          mode;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [10:0] lut [32];
    logic [10:0] noise;
    int          hold2;
    logic [15:0] last_sig;
    logic [8:0]  last_ones;

    logic [4:0]  vec0, vec2, vecz;
    logic [10:0] resp0, resp2, respz;
    logic        busy0, busy2, busyz, done0, done2, donez;
    logic [15:0] sig0, sig2, sigz;
    logic [8:0]  ones0, ones2, onesz;

    always #5 clk = ~clk;

    ccg_sig_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .vec_o(vec0), .resp_i(resp0),
        .busy(busy0), .done(done0), .signature(sig0), .ones_total(ones0)
    );

    ccg_sig_sweeper #(.SETTLE(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .vec_o(vec2), .resp_i(resp2),
        .busy(busy2), .done(done2), .signature(sig2), .ones_total(ones2)
    );

    ccg_sig_sweeper #(.SEED(16'h0000)) dut_z (
        .clk(clk), .rst(rst), .start(start), .vec_o(vecz), .resp_i(respz),
        .busy(busyz), .done(donez), .signature(sigz), .ones_total(onesz)
    );

    // Original netlist: linear gate chains
    function automatic logic [10:0] net_orig(input logic [4:0] v);
        logic a, b, c, d, e;
        {e, d, c, b, a} = v;
        return {7'({2'b00, v} + {v, 2'b00}), ((a & b) | (c & d)) | e,
                (((a | b) | c) | d) | e, (((a & b) & c) & d) & e, (((a ^ b) ^ c) ^ d) ^ e};
    endfunction

    // Balanced netlist: same function, re-associated trees
    function automatic logic [10:0] net_bal(input logic [4:0] v);
        logic a, b, c, d, e;
        {e, d, c, b, a} = v;
        return {7'({v, 2'b00} + {2'b00, v}), e | ((c & d) | (a & b)),
                ((a | b) | (c | d)) | e, ((a & b) & (c & d)) & e, ((a ^ b) ^ (c ^ d)) ^ e};
    endfunction

    function automatic logic [10:0] resp_f(input int md, input logic [4:0] v);
        case (md)
            0:       return 11'h000;
            1:       return {6'b0, v};
            2:       return 11'h7FF;
            3:       return lut[v];
            4:       return net_orig(v);
            5:       return net_bal(v);
            default: return net_orig(v) ^ 11'h010;
        endcase
    endfunction

    function automatic logic [15:0] ref_sig(input logic [15:0] seed);
        logic [15:0] m;
        m = seed;
        for (int v = 0; v < 32; v++)
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {5'b0, resp_f(mode, 5'(v))};
        return m;
    endfunction

    function automatic logic [8:0] ref_ones();
        int s;
        s = 0;
        for (int v = 0; v < 32; v++) s += $countones(resp_f(mode, 5'(v)));
        return 9'(s);
    endfunction

    always_comb begin
        resp0 = resp_f(mode, vec0);
        respz = resp_f(mode, vecz);
        resp2 = (hold2 == 2) ? resp_f(mode, vec2) : noise;
    end

    // Tracks which hold cycle dut_s2 is in so non-final cycles can carry garbage
    always @(posedge clk) begin
        hold2 <= !busy2 ? 0 : (hold2 == 2 ? 0 : hold2 + 1);
        noise <= 11'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input int m, input bit pulse, input int rst_at);
        int nd0, nd2, ndz;
        logic [15:0] es, ez;
        logic [8:0]  eo;
        mode = m;
        if (m == 3) foreach (lut[i]) lut[i] = 11'($urandom);
        es = ref_sig(16'hFFFF);
        ez = ref_sig(16'h0000);
        eo = ref_ones();
        nd0 = 0; nd2 = 0; ndz = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_at_start", 32'(busy0), 1);
        chk("vec_at_start", 32'(vec0), 0);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = pulse && (n == 10);
            if (n == rst_at) begin
                chk("vec_before_rst", 32'(vec0), 17);
                rst = 1'b1;
                #1;
                chk("rst_vec", 32'(vec0), 0);
                chk("rst_busy", 32'(busy0), 0);
                chk("rst_sig", 32'(sig0), 32'hFFFF);
                chk("rst_ones", 32'(ones0), 0);
                @(negedge clk) rst = 1'b0;
                return;
            end
            if (m == 2 && n < 32) chk("vec_seq", 32'(vec0), 32'(n));
            if (done0 && nd0 == 0) begin
                nd0 = n;
                chk("sig", 32'(sig0), 32'(es));
                chk("ones", 32'(ones0), 32'(eo));
                chk("busy_in_done", 32'(busy0), 0);
            end
            if (nd0 != 0 && n == nd0 + 1) chk("done_pulse", 32'(done0), 0);
            if (done2 && nd2 == 0) begin
                nd2 = n;
                chk("sig_s2", 32'(sig2), 32'(es));
                chk("ones_s2", 32'(ones2), 32'(eo));
            end
            if (donez && ndz == 0) begin
                ndz = n;
                chk("sig_z", 32'(sigz), 32'(ez));
                chk("ones_z", 32'(onesz), 32'(eo));
            end
        end
        chk("latency", 32'(nd0), 32);
        chk("latency_s2", 32'(nd2), 96);
        chk("latency_z", 32'(ndz), 32);
        chk("sig_held", 32'(sig0), 32'(es));
        last_sig = sig0;
        last_ones = ones0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_sig", 32'(sig0), 32'hFFFF);
        chk("reset_sig_z", 32'(sigz), 0);
        chk("reset_ones", 32'(ones0), 0);
        chk("reset_busy", 32'(busy0), 0);
        chk("reset_done", 32'(done0), 0);
        chk("reset_vec", 32'(vec0), 0);
        rst = 1'b0;
        run_sweep(0, 1'b0, -1);
        chk("zero_sig_z", 32'(sigz), 0);
        chk("zero_ones", 32'(ones0), 0);
        run_sweep(1, 1'b0, -1);
        chk("ident_ones", 32'(ones0), 80);
        run_sweep(2, 1'b0, -1);
        chk("const_ones", 32'(ones0), 352);
        run_sweep(3, 1'b1, -1);
        run_sweep(3, 1'b0, 17);
        run_sweep(3, 1'b0, -1);
        run_sweep(4, 1'b0, -1);
        run_sweep(5, 1'b0, -1);
        chk("pair_sig", 32'(sig0), 32'(net_sig_save(1'b0)));
        chk("pair_ones", 32'(ones0), 32'(last_ones));
        run_sweep(6, 1'b0, -1);
        chk("inv_differs", 32'(sig0 != net_sig_save(1'b0)), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    logic [15:0] orig_sig;
    always @(negedge clk) if (mode == 4 && done0) orig_sig <= sig0;

    function automatic logic [15:0] net_sig_save(input logic unused_sel);
        return unused_sel ? 16'h0000 : orig_sig;
    endfunction

endmodule
